// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - access size encodings (SZ_*)
//   - responder FSM state enum
//   - RAM byte write-enable mask constants (WE_*)
//   - latched request descriptor and the alignment check helper
package mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [BE_W-1:0] WE_NONE    = 4'b0000;
    localparam logic [BE_W-1:0] WE_BYTE0   = 4'b0001;
    localparam logic [BE_W-1:0] WE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] WE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] WE_WORD    = 4'b1111;

    // Request fields that must survive past the accept cycle.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] off;
    } req_t;

    // Reserved size, or an offset that is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load result formatter (combinational).
//   rdata  : raw 32-bit RAM word
//   offset : byte offset within the word
//   size   : access size (SZ_*)
//   sgn    : sign-extend byte/half results
//   data   : right-justified, extended load value
module dmem_load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            sgn,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data = sgn ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            SZ_HALF: data = sgn ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time between the MEM-stage
// initiator and a single-port, one-cycle-latency, word-addressed block RAM.
//   clk, resetn                      : clock, async active-low reset
//   req_valid/req_ready              : request handshake
//   req_we/size/signed/addr/wdata    : request payload
//   rsp_valid/rsp_ready              : response handshake
//   rsp_rdata/rsp_err                : formatted load data, alignment error
//   ram_en/we/addr/wdata, ram_rdata  : block RAM port
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned RAM_AW = 30
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic [BE_W-1:0]   ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    input  logic [XLEN-1:0]   ram_rdata
);

    state_e            state, state_next;
    req_t              req_q, req_d;
    logic              req_ready_d, rsp_valid_d, rsp_err_d, ram_en_d;
    logic [XLEN-1:0]   rsp_rdata_d, ram_wdata_d, load_data, wdata_repl;
    logic [BE_W-1:0]   ram_we_d, store_mask;
    logic [RAM_AW-1:0] ram_addr_d;
    logic              req_bad;

    assign req_bad = is_misaligned(req_size, req_addr[1:0]);

    dmem_load_align u_align (
        .rdata  (ram_rdata),
        .offset (req_q.off),
        .size   (req_q.size),
        .sgn    (req_q.sgn),
        .data   (load_data)
    );

    // Store byte mask and lane replication, from the live request.
    always_comb begin
        case (req_size)
            SZ_BYTE: begin
                store_mask = BE_W'(WE_BYTE0 << req_addr[1:0]);
                wdata_repl = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                store_mask = req_addr[1] ? WE_HALF_HI : WE_HALF_LO;
                wdata_repl = {2{req_wdata[15:0]}};
            end
            default: begin
                store_mask = WE_WORD;
                wdata_repl = req_wdata;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= WE_NONE;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state     <= state_next;
            req_q     <= req_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            ram_en    <= ram_en_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) state_next = req_bad ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: state_next = req_q.we ? ST_RESP : ST_RDWAIT;
            ST_RDWAIT: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.size  = req_size;
                    req_d.sgn   = req_signed;
                    req_d.off   = req_addr[1:0];
                    ram_addr_d  = req_addr[RAM_AW+1:2];
                    ram_wdata_d = wdata_repl;
                    rsp_err_d   = req_bad;
                end
            end
            ST_RDWAIT: rsp_rdata_d = load_data;
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
        req_ready_d = (state_next == ST_IDLE);
        rsp_valid_d = (state_next == ST_RESP);
        ram_en_d    = (state_next == ST_ACCESS);
        // Only reachable from IDLE with the request still on the inputs.
        ram_we_d    = (state_next == ST_ACCESS && req_we) ? store_mask : WE_NONE;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a behavioural block RAM.
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int unsigned RAM_AW = 30;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    always #5 clk = ~clk;

    dmem_responder #(.RAM_AW(RAM_AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Single-port RAM, one-cycle read latency, read-before-write.
    logic [31:0] mem [0:255];
    logic [31:0] mem_w;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[7:0]];
            mem_w = mem[ram_addr[7:0]];
            for (int k = 0; k < 4; k++)
                if (ram_we[k]) mem_w[8*k +: 8] = ram_wdata[8*k +: 8];
            mem[ram_addr[7:0]] <= mem_w;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic reset_check(input string tag);
        check($sformatf("%s ctrl", tag),
              32'({req_ready, rsp_valid, rsp_err, ram_en, ram_we}), 32'h80);
        check($sformatf("%s rdata", tag), rsp_rdata, 32'h0);
        check($sformatf("%s ram_addr", tag), 32'(ram_addr), 32'h0);
        check($sformatf("%s ram_wdata", tag), ram_wdata, 32'h0);
    endtask

    // Present a request at a negedge; returns just after the accepting edge.
    task automatic send(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        check($sformatf("%s req_ready", tag), 32'(req_ready), 32'h1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Watch the RAM port until the response appears, then score it.
    task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_en,
                            input logic [3:0] exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wd, input logic do_ack);
        int          lat    = 0;
        logic        saw_en = 1'b0;
        logic [3:0]  we_s   = 4'h0;
        logic [31:0] wd_s   = '0;
        logic [31:0] addr_s = '0;
        exp_t        e;
        do begin
            @(negedge clk);
            lat++;
            if (ram_en) begin
                saw_en = 1'b1;
                we_s   = ram_we;
                wd_s   = ram_wdata;
                addr_s = 32'(ram_addr);
            end
        end while (!rsp_valid && lat < 20);
        check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s ram_en", tag), 32'(saw_en), 32'(exp_en));
        check($sformatf("%s ram_we", tag), 32'(we_s), 32'(exp_we));
        if (exp_en) check($sformatf("%s ram_addr", tag), addr_s, exp_addr);
        if (exp_we != 4'h0) check($sformatf("%s ram_wdata", tag), wd_s, exp_wd);
        if (sb.size() == 0) begin
            check($sformatf("%s scoreboard", tag), 32'(sb.size()), 32'h1);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s rsp_rdata", tag), rsp_rdata, e.rdata);
            check($sformatf("%s rsp_err", tag), 32'(rsp_err), 32'(e.err));
        end
        if (do_ack) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check($sformatf("%s after ack", tag),
                  32'({rsp_valid, rsp_err, req_ready}), 32'h1);
        end
    endtask

    // Full transaction; latency and RAM activity follow from the request kind.
    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [3:0] exp_we, input logic [31:0] exp_wd);
        int lat;
        lat = exp_err ? 1 : (we ? 2 : 3);
        send(tag, we, size, sgn, addr, wdata, exp_rdata, exp_err);
        wait_rsp(tag, lat, !exp_err, exp_we, addr >> 2, exp_wd, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        #2 resetn = 1'b0;
        #1 reset_check("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Word store / load
        txn("sw 0x10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF);
        txn("lw 0x10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0);
        // Byte store into the top lane -> word 4 = 0x80ADBEEF
        txn("sb 0x13", 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h12345680, 32'h0, 1'b0, 4'b1000, 32'h80808080);
        txn("lb 0x13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 4'b0000, 32'h0);
        txn("lbu 0x13", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 4'b0000, 32'h0);
        txn("lbu 0x10", 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'h000000EF, 1'b0, 4'b0000, 32'h0);
        txn("lbu 0x11", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'h000000BE, 1'b0, 4'b0000, 32'h0);
        txn("lb 0x12", 1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0, 4'b0000, 32'h0);
        txn("lhu 0x10", 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 4'b0000, 32'h0);
        txn("lh 0x12", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 4'b0000, 32'h0);
        // Half store into the upper half of word 8
        txn("sh 0x22", 1'b1, SZ_HALF, 1'b0, 32'h22, 32'hCAFE8001, 32'h0, 1'b0, 4'b1100, 32'h80018001);
        txn("lh 0x22", 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 4'b0000, 32'h0);
        txn("lhu 0x22", 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h00008001, 1'b0, 4'b0000, 32'h0);
        txn("lhu 0x20", 1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b0, 4'b0000, 32'h0);
        // Byte store at offset 1, word readback ignores req_signed
        txn("sb 0x41", 1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h0000005A, 32'h0, 1'b0, 4'b0010, 32'h5A5A5A5A);
        txn("lw 0x40", 1'b0, SZ_WORD, 1'b1, 32'h40, 32'h0, 32'h00005A00, 1'b0, 4'b0000, 32'h0);
        // Error paths: no RAM access, one-edge response
        txn("lh 0x21 err", 1'b0, SZ_HALF, 1'b1, 32'h21, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        txn("sw 0x06 err", 1'b1, SZ_WORD, 1'b0, 32'h06, 32'h11223344, 32'h0, 1'b1, 4'b0000, 32'h0);
        txn("rsvd err", 1'b0, SZ_RSVD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        // Misaligned store must not have touched memory
        txn("lw 0x04", 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 32'h00000000, 1'b0, 4'b0000, 32'h0);

        // Response backpressure with a second request waiting
        send("bp lw", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        wait_rsp("bp lw", 3, 1'b1, 4'b0000, 32'h4, 32'h0, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = SZ_BYTE;
        req_signed = 1'b1;
        req_addr   = 32'h13;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp hold %0d", i),
                  32'({rsp_valid, req_ready, ram_en}), 32'h4);
            check($sformatf("bp rdata %0d", i), rsp_rdata, 32'h80ADBEEF);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp after ack", 32'({rsp_valid, req_ready}), 32'h1);
        begin
            exp_t e;
            e.rdata = 32'hFFFFFF80;
            e.err   = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp("bp lb", 3, 1'b1, 4'b0000, 32'h4, 32'h0, 1'b1);

        // Reset during RDWAIT drops the load
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SZ_WORD;
        req_addr  = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("drop ram_en", 32'(ram_en), 32'h1);
        @(negedge clk);
        resetn = 1'b0;
        #1 reset_check("mid reset");
        @(negedge clk);
        resetn = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        check("no stale rsp", 32'(saw), 32'h0);
        txn("post rst lw", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h80010000, 1'b0, 4'b0000, 32'h0);
        txn("post rst lbu", 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 32'h000000AD, 1'b0, 4'b0000, 32'h0);

        check("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
